result_packer: RTL

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/result_packer.sv
// rtl/result_packer.sv - reassembles serialized result words into one wide tile
//
// Collects NUM_WORDS words of WORD_W bits arriving one per wren cycle and
// presents them as a single tile with a valid/ready handshake. The first word
// lands in the LSBs (slot 0).
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset_n    - asynchronous active-low reset
//   word_in    - one serialized result word
//   wren       - word_in is valid this cycle
//   tile_ready - downstream accepts tile_out
//   flush      - (RESULT_PACKER_FLUSH_EN only) emit a partial tile early
//   tile_out   - reassembled tile, word k at [WORD_W*k +: WORD_W]
//   tile_valid - tile_out holds a complete (or flushed) tile
//   word_count - number of words captured into the current tile
//   overflow   - sticky, a word arrived while a tile was pending and was dropped
//
// Optional feature macro: RESULT_PACKER_FLUSH_EN adds the flush input.

module result_packer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 9
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WORD_W-1:0]           word_in,
  input  logic                        wren,
  input  logic                        tile_ready,
`ifdef RESULT_PACKER_FLUSH_EN
  input  logic                        flush,
`endif
  output logic [WORD_W*NUM_WORDS-1:0] tile_out,
  output logic                        tile_valid,
  output logic [3:0]                  word_count,
  output logic                        overflow
);

  localparam int TILE_W = WORD_W * NUM_WORDS;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [3:0]          count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                flush_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      tile_q  <= '0;
      count_q <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tile_d    = tile_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    flush_req = 1'b0;
`ifdef RESULT_PACKER_FLUSH_EN
    flush_req = flush;
`endif

    case (state_q)
      COLLECT: begin
        // The count guard keeps word_count bounded even if state were corrupted.
        if (wren && (count_q < 4'(NUM_WORDS))) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (count_q == 4'(k)) begin
              tile_d[k*WORD_W +: WORD_W] = word_in;
            end
          end
          count_d = count_q + 4'd1;
        end
        // Decisions use the post-capture count so that wren+flush captures
        // first, and a word that fills the tile yields a normal full tile.
        if (count_d == 4'(NUM_WORDS)) begin
          state_d = HOLD;
        end else if (flush_req && (count_d != 4'd0)) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (tile_ready) begin
          state_d = COLLECT;
          tile_d  = '0;
          count_d = 4'd0;
          // A word arriving on the handshake starts the next tile.
          if (wren) begin
            tile_d[WORD_W-1:0] = word_in;
            count_d            = 4'd1;
          end
        end else if (wren) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign tile_out   = tile_q;
  assign tile_valid = (state_q == HOLD);
  assign word_count = count_q;
  assign overflow   = ovf_q;

endmodule
